snake_game_sm: RTL and testbench
================================

Name: snake_game_sm

Overview:
- Game-state sequencer for the snake display datapath.
- Owns snake body positions, length, food location and game state (idle / run / collect / win / lose).
- Drives Qw, Ql, Qc, Food, Length and Locations_Flat to the renderer, which converts grid cells to pixels.
- Grid is 16x16 cells. Location byte encoding: {y[3:0], x[3:0]}, i.e. location = y*16 + x.

Parameters:
- WIN_LEN, 15: Length value that ends the game as a win (4..15).
- INIT_HEAD, 8'h77: head cell after Start. Body trails to the left, initial direction right.
- INIT_FOOD, 8'h7C: first food cell after Start.
- LFSR_SEED, 8'hA5: reset value of the food LFSR (nonzero).

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous active-low reset.
- Tick  in  1  one-cycle move strobe from the clock divider.
- Start  in  1  one-cycle pulse: start a game from Qi; acknowledge from Qw/Ql.
- BtnU, BtnD, BtnL, BtnR  in  1 each  debounced one-cycle direction pulses.
- Qi, Qr, Qc, Qw, Ql  out  1 each  one-hot state outputs.
- Food  out  8  food cell location.
- Length  out  4  number of valid segments.
- Locations_Flat  out  128  segment k at bits [127-8k -: 8]; segment 0 is the head.

Behaviour:
- Reset (async, Reset_n=0):
  - State Qi.
  - Length=3; segments 0..2 = INIT_HEAD, INIT_HEAD-1, INIT_HEAD-2; all other segments = INIT_HEAD-2.
  - Food=INIT_FOOD; direction=right; LFSR=LFSR_SEED.
- LFSR: 8-bit Galois, x^8+x^6+x^5+x^4+1. Free-runs every clock in all states. Never produces 0, so food is never at cell 0x00.
- Direction register:
  - Button pulses are latched in any state. Priority when simultaneous: U>D>L>R.
  - A request opposite to the current committed direction is discarded.
  - The latched direction is committed on each accepted Tick.
- Qi:
  - Tick is ignored.
  - On Start: re-load the reset snake, Food and direction, then go to Qr next cycle.
- Qr, on Tick, compute next head nh from the head and the committed direction. Outcomes:
  - Wall exit (x or y would leave 0..15): go to Ql. Positions are unchanged.
  - Self hit: go to Ql. Hit means nh equals any segment 0..Length-2, or 0..Length-1 when nh==Food.
  - nh==Food (eat):
    - Shift segments down by one, seg0<=nh, Length<=Length+1.
    - If the new Length==WIN_LEN, go to Qw; otherwise go to Qc.
  - Otherwise (move):
    - Shift down by one, seg0<=nh; Length unchanged.
    - Slots >= Length take the new tail value, so unused slots never render a spurious block.
  - A move/eat update is visible on outputs the cycle after Tick (latency 1).
- Qc (food placement):
  - Each cycle, candidate = LFSR value; drive Food = candidate.
  - If the candidate matches no segment 0..Length-1, go to Qr. Otherwise stay in Qc and retry next cycle.
  - Qc stays high for the whole search, and Food is final in the last Qc cycle; the renderer latches Food on Qc.
  - Ticks arriving during Qc are dropped.
- Qw / Ql:
  - Positions, Length and Food are frozen; Tick is ignored.
  - Start goes to Qi. Re-initialisation happens on the following Start.
- Reset mid-game: immediate return to the reset values above, regardless of state.
- Length never exceeds 15. Eating when Length==15 cannot occur because WIN_LEN<=15.

Optional Feature:
- Macro: SNAKE_WRAP_WALLS_EN.
- Defined: walls wrap. x and y are taken modulo 16 (e.g. head 0x7F moving right gives nh=0x70), and wall exit never causes Ql. Self-hit rules are unchanged.
- Undefined: wall exit goes to Ql as specified above.

Test Plan:
- Reset_n low for 3 clocks, then release:
  - Qi=1.
  - Length=3; Locations_Flat[127:104]=0x77,0x76,0x75; all remaining bytes 0x75.
  - Food=0x7C; Qw=Ql=Qc=0.
- Start, then 3 Ticks with no buttons: head=0x7A, segments 1..2 = 0x79,0x78, Length=3, Qr=1.
- Start, then 5 Ticks: the 5th Tick gives head=0x7C, Length=4 and Qc high for at least 1 cycle. At Qc exit, Food is nonzero and matches none of 0x7C,0x7B,0x7A,0x79. Then Qr.
- Start, BtnU, then 7 Ticks: head=0x07. The 8th Tick gives Ql=1 with positions frozen. Start returns to Qi.
  - With SNAKE_WRAP_WALLS_EN defined, the 8th Tick instead gives head=0xF7 and Qr=1.
- Moving right, BtnL, then Tick: the reversal is discarded and head=0x78. BtnU and BtnR in the same cycle, then Tick: up is chosen and head=0x68.
- WIN_LEN=4: Start, then 5 Ticks: Qw=1 with Length=4 and Qc never asserted. Tick ignored afterward. Reset_n pulse mid-Qw returns to Qi.

Source files
------------

// File: rtl/snake_game_sm.sv
// snake_game_sm: snake game-state sequencer (body, length, food, direction, idle/run/collect/win/lose); define SNAKE_WRAP_WALLS_EN to wrap walls instead of losing
module snake_game_sm #(
  parameter int         WIN_LEN   = 15,
  parameter logic [7:0] INIT_HEAD = 8'h77,
  parameter logic [7:0] INIT_FOOD = 8'h7C,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Tick,
  input  logic         Start,
  input  logic         BtnU,
  input  logic         BtnD,
  input  logic         BtnL,
  input  logic         BtnR,
  output logic         Qi,
  output logic         Qr,
  output logic         Qc,
  output logic         Qw,
  output logic         Ql,
  output logic [7:0]   Food,
  output logic [3:0]   Length,
  output logic [127:0] Locations_Flat
);
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_COLL, S_WIN, S_LOSE} state_t;
  localparam logic [1:0] DIR_U = 2'd0, DIR_D = 2'd1, DIR_L = 2'd2, DIR_R = 2'd3;
  localparam logic [3:0] WIN = 4'(WIN_LEN);
  state_t     state_q, state_d;
  logic [7:0] seg_q [16];
  logic [7:0] seg_d [16];
  logic [3:0] len_q, len_d;
  logic [7:0] food_q, food_d, lfsr_q, lfsr_d;
  logic [1:0] dir_q, dir_d, req_q, req_d, btn_dir;
  logic [3:0] hx, hy;
  logic [7:0] nh, tail;
  logic       wall, hit, eat, free;

  function automatic logic [7:0] init_seg(input int k);
    return k == 0 ? INIT_HEAD : k == 1 ? INIT_HEAD - 8'd1 : INIT_HEAD - 8'd2;
  endfunction

  assign hx      = seg_q[0][3:0];
  assign hy      = seg_q[0][7:4];
  assign nh      = req_q == DIR_U ? {hy - 4'd1, hx} : req_q == DIR_D ? {hy + 4'd1, hx} :
                   req_q == DIR_L ? {hy, hx - 4'd1} : {hy, hx + 4'd1};
`ifdef SNAKE_WRAP_WALLS_EN
  assign wall    = 1'b0;
`else
  assign wall    = (req_q == DIR_U && hy == 4'd0) || (req_q == DIR_D && hy == 4'd15) ||
                   (req_q == DIR_L && hx == 4'd0) || (req_q == DIR_R && hx == 4'd15);
`endif
  assign eat     = nh == food_q;
  assign tail    = seg_q[len_q - 4'd2];
  assign btn_dir = BtnU ? DIR_U : BtnD ? DIR_D : BtnL ? DIR_L : DIR_R;

  // body collision for the next head (tail cell counts only when eating) and occupancy of the food candidate
  always_comb begin
    hit  = 1'b0;
    free = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k < int'(len_q) - (eat ? 0 : 1) && seg_q[k] == nh) hit = 1'b1;
      if (k < int'(len_q) && seg_q[k] == lfsr_q) free = 1'b0;
    end
  end

  // state register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = Start ? S_RUN : S_IDLE;
      S_RUN:   if (Tick) state_d = (wall || hit) ? S_LOSE : !eat ? S_RUN : (len_q + 4'd1 == WIN) ? S_WIN : S_COLL;
      S_COLL:  state_d = free ? S_RUN : S_COLL;
      default: state_d = Start ? S_IDLE : state_q;
    endcase
  end

  // datapath next values: direction latch/commit, body shift, food search, game re-initialisation
  always_comb begin
    seg_d  = seg_q;
    len_d  = len_q;
    food_d = food_q;
    dir_d  = dir_q;
    req_d  = ((BtnU | BtnD | BtnL | BtnR) && btn_dir != (dir_q ^ 2'd1)) ? btn_dir : req_q;
    lfsr_d = {lfsr_q[6:0], 1'b0} ^ (lfsr_q[7] ? 8'h71 : 8'h00);
    if (state_q == S_RUN && Tick) dir_d = req_q;
    if (state_q == S_RUN && Tick && !wall && !hit) begin
      seg_d[0] = nh;
      for (int k = 1; k < 16; k++) seg_d[k] = (eat || k < int'(len_q)) ? seg_q[k-1] : tail;
      len_d = len_q + {3'd0, eat};
    end
    if (state_q == S_COLL) food_d = lfsr_q;
    if (state_q == S_IDLE && Start) begin
      for (int k = 0; k < 16; k++) seg_d[k] = init_seg(k);
      len_d  = 4'd3;
      food_d = INIT_FOOD;
      dir_d  = DIR_R;
      req_d  = DIR_R;
    end
  end

  // datapath registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int k = 0; k < 16; k++) seg_q[k] <= init_seg(k);
      len_q  <= 4'd3;
      food_q <= INIT_FOOD;
      dir_q  <= DIR_R;
      req_q  <= DIR_R;
      lfsr_q <= LFSR_SEED;
    end else begin
      seg_q  <= seg_d;
      len_q  <= len_d;
      food_q <= food_d;
      dir_q  <= dir_d;
      req_q  <= req_d;
      lfsr_q <= lfsr_d;
    end
  end

  // outputs: one-hot state, live food candidate during search, flattened body
  always_comb begin
    Qi     = state_q == S_IDLE;
    Qr     = state_q == S_RUN;
    Qc     = state_q == S_COLL;
    Qw     = state_q == S_WIN;
    Ql     = state_q == S_LOSE;
    Food   = state_q == S_COLL ? lfsr_q : food_q;
    Length = len_q;
    Locations_Flat = '0;
    for (int k = 0; k < 16; k++) Locations_Flat[127-8*k -: 8] = seg_q[k];
  end
endmodule

// File: tb/tb_snake_game_sm.sv
// tb_snake_game_sm: directed and random checks of snake_game_sm against a queue-based game model
module tb_snake_game_sm;
  logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0, start = 1'b0;
  logic bu = 1'b0, bd = 1'b0, bl = 1'b0, br = 1'b0;
  logic qi, qr, qc, qw, ql, w_qi, w_qr, w_qc, w_qw, w_ql;
  logic [7:0] food, w_food;
  logic [3:0] len, w_len;
  logic [127:0] flat, w_flat;
  int vectors = 0, miscompares = 0;
  bit chk_en = 1'b0, w_qc_seen = 1'b0;
  bit [7:0] body[$];
  bit [7:0] exp_body[$];
  int mst, mdir, mreq;
  bit [7:0] mfood, mlfsr;
  int dx[4] = '{0, 0, -1, 1};
  int dy[4] = '{-1, 1, 0, 0};
  int opp[4] = '{1, 0, 3, 2};

  always #5 clk = ~clk;

  snake_game_sm dut (
    .Clk(clk), .Reset_n(rst_n), .Tick(tick), .Start(start),
    .BtnU(bu), .BtnD(bd), .BtnL(bl), .BtnR(br),
    .Qi(qi), .Qr(qr), .Qc(qc), .Qw(qw), .Ql(ql),
    .Food(food), .Length(len), .Locations_Flat(flat)
  );

  snake_game_sm #(.WIN_LEN(4)) dut_w (
    .Clk(clk), .Reset_n(rst_n), .Tick(tick), .Start(start),
    .BtnU(bu), .BtnD(bd), .BtnL(bl), .BtnR(br),
    .Qi(w_qi), .Qr(w_qr), .Qc(w_qc), .Qw(w_qw), .Ql(w_ql),
    .Food(w_food), .Length(w_len), .Locations_Flat(w_flat)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit [7:0] mulx(input bit [7:0] v);
    bit [8:0] p;
    p = {v, 1'b0};
    return p[8] ? (p[7:0] ^ 8'h71) : p[7:0];
  endfunction

  function automatic logic [127:0] flat_of(input bit [7:0] s[$]);
    logic [127:0] f;
    for (int k = 0; k < 16; k++) f[127-8*k -: 8] = k < s.size() ? s[k] : s[s.size()-1];
    return f;
  endfunction

  task automatic model_init_game();
    body  = {8'h77, 8'h76, 8'h75};
    mfood = 8'h7C;
    mdir  = 3;
    mreq  = 3;
  endtask

  task automatic model_step();
    int p, nx, ny, old_req, old_dir;
    bit [7:0] cand, nh;
    bit hit, wall, eat;
    old_req = mreq;
    old_dir = mdir;
    cand    = mlfsr;
    mlfsr   = mulx(mlfsr);
    p = bu ? 0 : bd ? 1 : bl ? 2 : br ? 3 : -1;
    if (p >= 0 && p != opp[old_dir]) mreq = p;
    case (mst)
      0: if (start) begin model_init_game(); mst = 1; end
      1: if (tick) begin
        mdir = old_req;
        nx = int'(body[0][3:0]) + dx[old_req];
        ny = int'(body[0][7:4]) + dy[old_req];
`ifdef SNAKE_WRAP_WALLS_EN
        nx = (nx + 16) % 16;
        ny = (ny + 16) % 16;
        wall = 1'b0;
`else
        wall = nx < 0 || nx > 15 || ny < 0 || ny > 15;
`endif
        if (wall) mst = 4;
        else begin
          nh  = 8'(ny * 16 + nx);
          eat = nh == mfood;
          hit = 1'b0;
          for (int k = 0; k < body.size() - (eat ? 0 : 1); k++) if (body[k] == nh) hit = 1'b1;
          if (hit) mst = 4;
          else begin
            body.push_front(nh);
            if (!eat) void'(body.pop_back());
            else mst = body.size() == 15 ? 3 : 2;
          end
        end
      end
      2: begin
        mfood = cand;
        mst = 1;
        foreach (body[k]) if (body[k] == cand) mst = 2;
      end
      default: if (start) mst = 0;
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_init_game();
      mst   = 0;
      mlfsr = 8'hA5;
    end else model_step();
  end

  always @(negedge clk) begin
    if (w_qc) w_qc_seen = 1'b1;
    if (chk_en) begin
      chk("state", {qi, qr, qc, qw, ql}, 5'b10000 >> mst);
      chk("length", len, body.size());
      chk("food", food, mst == 2 ? mlfsr : mfood);
      chk("flat", flat, flat_of(body));
    end
  end

  task automatic step(input bit t = 0, input bit s = 0, input bit u = 0, input bit d = 0,
                      input bit l = 0, input bit r = 0);
    tick = t; start = s; bu = u; bd = d; bl = l; br = r;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    do_reset();
    chk_en = 1'b1;
    chk("rst_qi", qi, 1);
    chk("rst_len", len, 3);
    chk("rst_flat", flat, {8'h77, 8'h76, {14{8'h75}}});
    chk("rst_food", food, 8'h7C);
    chk("rst_qwlc", {qw, ql, qc}, 0);

    step(0, 1);
    repeat (3) step(1);
    chk("run3_body", flat[127:104], 24'h7A7978);
    chk("run3_len", len, 3);
    chk("run3_qr", qr, 1);

    do_reset();
    step(0, 1);
    repeat (5) step(1);
    chk("eat_head", flat[127:120], 8'h7C);
    chk("eat_len", len, 4);
    chk("eat_qc", qc, 1);
    n = 0;
    while (qc && n < 300) begin step(); n++; end
    chk("qc_exit", qc, 0);
    chk("food_ok", food != 8'h00 && !(food inside {8'h7C, 8'h7B, 8'h7A, 8'h79}), 1);
    chk("qc_to_qr", qr, 1);

    do_reset();
    step(0, 1);
    step(0, 0, 1);
    repeat (7) step(1);
    chk("up7_head", flat[127:120], 8'h07);
    step(1);
`ifdef SNAKE_WRAP_WALLS_EN
    chk("wrap_head", flat[127:120], 8'hF7);
    chk("wrap_qr", qr, 1);
`else
    chk("wall_ql", ql, 1);
    exp_body = {8'h07, 8'h17, 8'h27};
    chk("wall_frozen", flat, flat_of(exp_body));
    step(0, 1);
    chk("lose_to_qi", qi, 1);
`endif

    do_reset();
    step(0, 1);
    step(0, 0, 0, 0, 1);
    step(1);
    chk("rev_head", flat[127:120], 8'h78);
    step(0, 0, 1, 0, 0, 1);
    step(1);
    chk("prio_head", flat[127:120], 8'h68);

    do_reset();
    w_qc_seen = 1'b0;
    step(0, 1);
    repeat (5) step(1);
    chk("win_qw", w_qw, 1);
    chk("win_len", w_len, 4);
    chk("win_noqc", w_qc_seen, 0);
    step(1);
    exp_body = {8'h7C, 8'h7B, 8'h7A, 8'h79};
    chk("win_frozen", w_flat, flat_of(exp_body));
    chk("win_hold", w_qw, 1);
    rst_n = 1'b0;
    #1;
    chk("win_rst_qi", w_qi, 1);
    step();
    rst_n = 1'b1;
    step();

    repeat (3000) begin
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      step($urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
